if_stage: RTL and testbench

//   Instruction-fetch stage directly upstream of id_stage. Holds the PC and issues

---
 rtl/if_stage.sv | 123 ++++++++++++
 tb/tb_if_stage.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem fetch and a
// 2-entry instruction queue feeding decode; execute redirects flush the queue.
module if_stage #(
    parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_addr
);
    localparam logic [1:0] QMAX = 2'(QDEPTH);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_e;
    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] addr;
    } entry_t;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] fetch_pc_q, fetch_pc_d;
    logic [1:0]  count_q, count_d;
    logic        head_q, head_d;
    entry_t      queue_q [2];

    logic req_ok, req_fire, enq, pop, tail;

    // A redirect withdraws any pending request in the same cycle.
    assign req_ok   = (state_q == S_REQ) && (count_q < QMAX) && !redirect_valid;
    assign req_fire = req_ok && imem_req_ready;
    assign enq      = (state_q == S_WAIT) && imem_resp_valid && !redirect_valid;
    assign pop      = id_valid && id_ready;
    assign tail     = head_q ^ count_q[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_REQ;
            pc_q       <= PC_RESET;
            fetch_pc_q <= '0;
            count_q    <= '0;
            head_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            head_q     <= head_d;
        end
    end

    // NOTE: queue storage is not reset; count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (enq) begin
            queue_q[tail] <= '{inst: imem_resp_data, addr: fetch_pc_q};
        end
    end

    // NOTE: every comb output gets a default first so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_REQ:   if (req_fire) state_d = S_WAIT;
            S_WAIT:  begin
                if (imem_resp_valid)     state_d = S_REQ;
                else if (redirect_valid) state_d = S_DROP;
            end
            S_DROP:  if (imem_resp_valid) state_d = S_REQ;
            default: state_d = S_REQ;
        endcase
    end

    always_comb begin
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        head_d     = head_q;
        if (req_fire) begin
            fetch_pc_d = pc_q;
            pc_d       = pc_q + 64'd4;
        end
        if (redirect_valid) begin
            pc_d    = redirect_pc & ~64'h3;
            count_d = '0;
        end else begin
            if (pop) head_d = ~head_q;
            count_d = count_q + {1'b0, enq} - {1'b0, pop};
        end
    end

    // Outputs are held at zero while reset is asserted.
    always_comb begin
        imem_req_valid = 1'b0;
        imem_req_addr  = '0;
        id_valid       = (count_q != 2'd0) && !redirect_valid;
        inst           = '0;
        inst_addr      = '0;
        if (rst) begin
            imem_req_valid = req_ok;
            imem_req_addr  = pc_q;
        end
        if (count_q != 2'd0) begin
            inst      = queue_q[head_q].inst;
            inst_addr = queue_q[head_q].addr;
        end
    end

`ifndef SYNTHESIS
    resp_in_req_a: assert property (@(posedge clk) disable iff (!rst)
        !((state_q == S_REQ) && imem_resp_valid))
        else $error("imem response arrived with no request outstanding");
`endif

endmodule

// File: tb/tb_if_stage.sv
// Randomized scoreboard bench for if_stage: a queue-based reference model predicts
// fetch addresses and the decode stream; a monitor compares every cycle.
module tb_if_stage;
    localparam logic [63:0] PC_RESET = 64'h0000_0000_8000_0000;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] inst;
    logic [63:0] inst_addr;

    int n_checks = 0;
    int n_errors = 0;
    int n_decoded = 0;

    exp_t        exp_q[$];
    logic [63:0] m_pc = PC_RESET;
    logic [63:0] m_fetch_pc = '0;
    bit          m_busy = 0;
    bit          m_stale = 0;
    bit          exp_rv_s = 0;

    bit          mem_pending = 0;
    int          mem_delay = 0;
    logic [31:0] mem_data = '0;
    int          lat_min = 0;
    int          lat_max = 0;

    if_stage #(.PC_RESET(PC_RESET), .QDEPTH(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .inst            (inst),
        .inst_addr       (inst_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; the monitor samples 3 time units later.
    task automatic drive(input bit r, input bit rdy, input bit idr, input bit redir,
                         input logic [63:0] rpc);
        @(negedge clk);
        rst             = r;
        imem_req_ready  = rdy;
        id_ready        = idr;
        redirect_valid  = redir;
        redirect_pc     = rpc;
        imem_resp_valid = r && mem_pending && (mem_delay == 0);
        imem_resp_data  = imem_resp_valid ? mem_data : 32'($urandom);
    endtask

    function automatic logic [63:0] pick_target();
        logic [63:0] t;
        case ($urandom_range(0, 3))
            0:       t = {32'($urandom), 32'($urandom)};
            1:       t = 64'hFFFF_FFFF_FFFF_FFF8 | 64'($urandom_range(0, 7));
            2:       t = PC_RESET + 64'($urandom_range(0, 255));
            default: t = 64'h0000_0000_8000_1002;
        endcase
        return t;
    endfunction

    task automatic rand_phase(input int n, input int p_rdy, input int p_idr, input int p_redir);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, int'($urandom_range(0, 99)) < p_rdy, int'($urandom_range(0, 99)) < p_idr,
                  int'($urandom_range(0, 99)) < p_redir, pick_target());
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("async_rst_req_valid", imem_req_valid, 0);
        check("async_rst_req_addr", imem_req_addr, 0);
        check("async_rst_id_valid", id_valid, 0);
        check("async_rst_inst", inst, 0);
        check("async_rst_inst_addr", inst_addr, 0);
        repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    // Monitor / scoreboard: compares DUT outputs with the model every cycle.
    initial begin : monitor
        bit   exp_iv;
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!rst) begin
                exp_rv_s = 0;
                check("rst_req_valid", imem_req_valid, 0);
                check("rst_req_addr", imem_req_addr, 0);
                check("rst_id_valid", id_valid, 0);
                check("rst_inst", inst, 0);
                check("rst_inst_addr", inst_addr, 0);
            end else begin
                exp_rv_s = !m_busy && (exp_q.size() < 2) && !redirect_valid;
                exp_iv   = (exp_q.size() != 0) && !redirect_valid;
                check("req_valid", imem_req_valid, exp_rv_s);
                if (exp_rv_s) check("req_addr", imem_req_addr, m_pc);
                check("id_valid", id_valid, exp_iv);
                if (exp_q.size() == 0) begin
                    check("empty_inst", inst, 0);
                    check("empty_inst_addr", inst_addr, 0);
                end else if (exp_iv && id_ready) begin
                    e = exp_q.pop_front();
                    check("inst", inst, e.inst);
                    check("inst_addr", inst_addr, e.addr);
                    n_decoded++;
                end
            end
        end
    end

    // Reference model: next fetch PC, one outstanding fetch (possibly stale), and the
    // expected decode stream as a queue; runs after the monitor in each cycle.
    initial begin : model
        forever begin
            @(negedge clk);
            #4;
            if (!rst) begin
                m_pc = PC_RESET;
                m_busy = 0;
                m_stale = 0;
                exp_q.delete();
            end else if (redirect_valid) begin
                exp_q.delete();
                m_pc = redirect_pc & ~64'h3;
                if (m_busy) begin
                    if (imem_resp_valid) begin
                        m_busy = 0;
                        m_stale = 0;
                    end else begin
                        m_stale = 1;
                    end
                end
            end else if (m_busy && imem_resp_valid) begin
                if (!m_stale) exp_q.push_back('{inst: imem_resp_data, addr: m_fetch_pc});
                m_busy = 0;
                m_stale = 0;
            end else if (exp_rv_s && imem_req_ready) begin
                m_fetch_pc = m_pc;
                m_pc = m_pc + 64'd4;
                m_busy = 1;
            end
        end
    end

    // Instruction memory: one pending fetch, answered lat_min..lat_max cycles late.
    initial begin : memory
        forever begin
            @(negedge clk);
            #4;
            if (!rst) begin
                mem_pending = 0;
            end else begin
                if (imem_resp_valid) mem_pending = 0;
                else if (mem_pending && mem_delay > 0) mem_delay--;
                if (imem_req_valid && imem_req_ready) begin
                    mem_pending = 1;
                    mem_delay = int'($urandom_range(lat_min, lat_max));
                    mem_data = 32'($urandom);
                end
            end
        end
    end

    initial begin : stimulus
        int   first_acc;
        int   first_id;
        bit   acc;
        logic [63:0] acc_addrs[$];

        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, '0);

        // Latency: accept at cycle 0, response next cycle, id_valid one cycle later.
        lat_min = 0;
        lat_max = 0;
        first_acc = -1;
        first_id = -1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
            #3;
            if (first_acc < 0 && imem_req_valid && imem_req_ready) first_acc = i;
            if (first_id < 0 && id_valid) first_id = i;
        end
        check("first_accept_cycle", 64'(first_acc), 64'(0));
        check("first_decode_cycle", 64'(first_id), 64'(2));

        // Decode stalled: queue fills to two entries and fetch stops.
        repeat (10) drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
        #3;
        check("full_req_valid", imem_req_valid, 0);
        check("full_id_valid", id_valid, 1);
        // Redirect with a full queue and decode ready: no pop, queue flushed.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 64'h0000_0000_8000_2000);
        #3;
        check("flush_id_valid", id_valid, 0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, '0);
        #3;
        check("post_flush_id_valid", id_valid, 0);
        repeat (10) drive(1'b1, 1'b1, 1'b1, 1'b0, '0);

        // Redirect while a fetch is outstanding: its response must be dropped.
        lat_min = 2;
        lat_max = 2;
        acc = 0;
        for (int i = 0; i < 6 && !acc; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
            #3;
            acc = imem_req_valid && imem_req_ready;
        end
        check("reached_wait", acc, 1);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 64'h0000_0000_8000_1002);
        repeat (10) drive(1'b1, 1'b1, 1'b1, 1'b0, '0);

        // Memory not ready for 5 cycles, redirect in the third.
        lat_min = 0;
        lat_max = 0;
        repeat (4) drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b1, i == 2, 64'h0000_0000_9000_0006);
            if (i == 3) begin
                #3;
                check("stalled_redirect_addr", imem_req_addr, 64'h0000_0000_9000_0004);
            end
        end
        repeat (4) drive(1'b1, 1'b1, 1'b1, 1'b0, '0);

        // PC wrap at the top of the address space.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        for (int i = 0; i < 20 && acc_addrs.size() < 2; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
            #3;
            if (imem_req_valid && imem_req_ready) acc_addrs.push_back(imem_req_addr);
        end
        check("wrap_fetch_count", 64'(acc_addrs.size()), 64'(2));
        if (acc_addrs.size() == 2) begin
            check("wrap_first_addr", acc_addrs[0], 64'hFFFF_FFFF_FFFF_FFFC);
            check("wrap_second_addr", acc_addrs[1], 64'h0);
        end

        // Reset asserted while a fetch is outstanding.
        lat_min = 3;
        lat_max = 3;
        acc = 0;
        for (int i = 0; i < 6 && !acc; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
            #3;
            acc = imem_req_valid && imem_req_ready;
        end
        check("reached_wait_before_reset", acc, 1);
        async_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
        #3;
        check("post_reset_req_valid", imem_req_valid, 1);
        check("post_reset_req_addr", imem_req_addr, PC_RESET);

        // Randomized traffic under several mixes.
        lat_min = 0;
        lat_max = 3;
        rand_phase(1500, 70, 70, 5);
        rand_phase(800, 90, 20, 2);
        rand_phase(800, 40, 95, 10);
        lat_max = 1;
        rand_phase(800, 100, 100, 0);
        repeat (6) drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
        check("decode_progress", n_decoded > 200, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
